box_plotter: RTL and testbench
==============================

# box_plotter

Downstream stage of the box-reset sequencer. Accepts one box request per cycle (top-left pixel plus colour) into a small FIFO. Expands each request into a BOX_W × BOX_H block of single-pixel writes for the VGA adapter, one pixel per clock, with no gap between consecutive boxes.

## Interface
Parameters:
- BOX_W, 3, box width in pixels (1–15)
- BOX_H, 3, box height in pixels (1–15)
- FIFO_DEPTH, 4, request FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  FIFO can accept; equals !full
- in_x  in  8  box left column
- in_y  in  7  box top row
- in_colour  in  3  box colour
- vga_x  out  8  pixel column
- vga_y  out  7  pixel row
- vga_colour  out  3  pixel colour
- vga_plot  out  1  pixel write enable
- busy  out  1  high when the state is DRAW or the FIFO is non-empty
- box_done  out  1  one-cycle pulse coincident with a box's last pixel

## Operation
- Push: on an edge where in_valid && in_ready, {in_x, in_y, in_colour} is written at the tail. Requests with in_valid low are ignored.
- in_ready is derived from full before any same-cycle pop. When the FIFO is full there is no push, even if a pop occurs in that cycle.
- FSM states: IDLE, DRAW.
  - IDLE: if the FIFO is non-empty, pop the head into job registers (bx, by, bc), clear cx and cy, and go to DRAW. Otherwise stay in IDLE.
  - DRAW, every edge: register vga_x = bx+cx, vga_y = by+cy, vga_colour = bc, vga_plot = 1. Then advance cx; at cx == BOX_W-1, set cx = 0 and increment cy.
  - Last pixel (cx == BOX_W-1 && cy == BOX_H-1): assert box_done with this pixel. If the FIFO is non-empty, pop the next job in the same edge and stay in DRAW. Otherwise go to IDLE.
- Pixel order within a box is row-major: left to right, then top to bottom.
- Arithmetic: vga_x wraps modulo 256 and vga_y wraps modulo 128, unless clipping is compiled in.
- Outside DRAW: vga_plot = 0 and box_done = 0. vga_x, vga_y and vga_colour hold their last values.
- Reset (async, any time, including mid-box):
  - FIFO emptied; state IDLE; cx, cy, bx, by, bc = 0.
  - Outputs: vga_x = 0, vga_y = 0, vga_colour = 0, vga_plot = 0, box_done = 0, busy = 0, in_ready = 1.
  - A partially drawn box is abandoned.

## Timing
- Request accepted at edge E0, with the block in IDLE and the FIFO empty:
  - E1: job loaded, state DRAW.
  - Pixel k (0-based) is visible after edge E(2+k).
- Latency from acceptance to the first vga_plot is 2 cycles.
- A box occupies exactly BOX_W·BOX_H consecutive vga_plot cycles.
- Back-to-back boxes have 0 idle cycles between them when the next request is already queued.
- Throughput: one pixel per clock. A default 3×3 box takes 9 cycles, so the FIFO fills when the upstream stage issues one request per cycle.
- Push and pop in the same edge are allowed when not full; the occupancy count is unchanged.

## Configuration
- BOX_PLOTTER_CLIP_EN defined:
  - Pixel sums are computed 1 bit wider.
  - Any pixel with x ≥ 160 or y ≥ 120 gets vga_plot = 0.
  - Such a pixel still consumes its cycle; counters and box_done timing are unchanged.
- BOX_PLOTTER_CLIP_EN undefined: no clipping, sums wrap as described in Operation.

## Test plan
- Single box:
  - Stimulus: reset, then push (38, 4, 3'b111) once.
  - Response: vga_plot first high 2 cycles after acceptance.
  - Pixels in order: (38,4), (39,4), (40,4), (38,5) … (40,6); 9 plots total.
  - box_done high with (40,6); busy low the cycle after.
- Burst / backpressure:
  - Stimulus: in_valid held high for 8 cycles with distinct y values.
  - Response: in_ready drops when 4 requests are queued plus one in DRAW.
  - Exactly the accepted requests are drawn, in order, with no gaps between boxes.
- Simultaneous push/pop:
  - Stimulus: FIFO holds 2 entries; push one request on the edge where the current box's last pixel triggers a pop.
  - Response: occupancy stays 2; no entry lost or duplicated.
- Reset mid-box:
  - Stimulus: assert reset after pixel 4 of a box, with 2 entries queued.
  - Response: vga_plot = 0 immediately, in_ready = 1, busy = 0.
  - No further plots after reset is released until a new push.
- Wrap / clip:
  - Stimulus: push (158, 118, 3'b010).
  - Without the macro: 9 plots, including x = 160 and y = 120.
  - With BOX_PLOTTER_CLIP_EN: only (158,118), (159,118), (158,119), (159,119) have vga_plot = 1. box_done still occurs on cycle 9.

Source files
------------

// File: rtl/box_plotter_if.sv
// rtl/box_plotter_if.sv - box request port and VGA pixel-write port of box_plotter
interface box_plotter_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_x;
    logic [6:0] in_y;
    logic [2:0] in_colour;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       busy;
    logic       box_done;

    modport master (
        output in_valid, in_x, in_y, in_colour,
        input  in_ready, vga_x, vga_y, vga_colour, vga_plot, busy, box_done
    );

    modport slave (
        input  in_valid, in_x, in_y, in_colour,
        output in_ready, vga_x, vga_y, vga_colour, vga_plot, busy, box_done
    );
endinterface

// File: rtl/box_plotter.sv
// rtl/box_plotter.sv - queues box requests and expands each into BOX_W x BOX_H pixel writes
// Optional screen clipping (x >= 160 or y >= 120 suppressed) via BOX_PLOTTER_CLIP_EN.
module box_plotter #(
    parameter int BOX_W      = 3,
    parameter int BOX_H      = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    box_plotter_if.slave  bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

`ifdef BOX_PLOTTER_CLIP_EN
    localparam int XW = 9;
    localparam int YW = 8;
`else
    localparam int XW = 8;
    localparam int YW = 7;
`endif

    typedef enum logic {IDLE, DRAW} state_t;

    state_t      state_q, state_d;
    logic [17:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0] count_q, count_d;
    logic [3:0]  cx_q, cx_d, cy_q, cy_d;
    logic [7:0]  bx_q, bx_d;
    logic [6:0]  by_q, by_d;
    logic [2:0]  bc_q, bc_d;
    logic [7:0]  vga_x_q, vga_x_d;
    logic [6:0]  vga_y_q, vga_y_d;
    logic [2:0]  vga_colour_q, vga_colour_d;
    logic        vga_plot_q, vga_plot_d;
    logic        box_done_q, box_done_d;

    logic        full, empty, push, pop, last_px;
    logic [17:0] head;
    logic [XW-1:0] sum_x;
    logic [YW-1:0] sum_y;

    // Full is taken before any same-edge pop, so a full FIFO never accepts.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign push    = bus.in_valid && !full;
    assign head    = mem_q[rd_ptr_q];
    assign last_px = (cx_q == 4'(BOX_W - 1)) && (cy_q == 4'(BOX_H - 1));
    assign sum_x   = XW'(bx_q) + XW'(cx_q);
    assign sum_y   = YW'(by_q) + YW'(cy_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!empty) state_d = DRAW;
            DRAW:    if (last_px && empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pop          = 1'b0;
        cx_d         = cx_q;
        cy_d         = cy_q;
        bx_d         = bx_q;
        by_d         = by_q;
        bc_d         = bc_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        box_done_d   = 1'b0;
        case (state_q)
            IDLE: pop = !empty;
            DRAW: begin
                vga_x_d      = sum_x[7:0];
                vga_y_d      = sum_y[6:0];
                vga_colour_d = bc_q;
`ifdef BOX_PLOTTER_CLIP_EN
                vga_plot_d   = (sum_x < XW'(160)) && (sum_y < YW'(120));
`else
                vga_plot_d   = 1'b1;
`endif
                box_done_d   = last_px;
                if (cx_q == 4'(BOX_W - 1)) begin
                    cx_d = '0;
                    cy_d = last_px ? 4'd0 : cy_q + 4'd1;
                end else begin
                    cx_d = cx_q + 4'd1;
                end
                pop = last_px && !empty;
            end
            default: pop = 1'b0;
        endcase
        if (pop) begin
            bx_d = head[17:10];
            by_d = head[9:3];
            bc_d = head[2:0];
            cx_d = '0;
            cy_d = '0;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset; emptiness is carried by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.in_x, bus.in_y, bus.in_colour};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            cx_q         <= '0;
            cy_q         <= '0;
            bx_q         <= '0;
            by_q         <= '0;
            bc_q         <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            box_done_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q      <= count_d;
            cx_q         <= cx_d;
            cy_q         <= cy_d;
            bx_q         <= bx_d;
            by_q         <= by_d;
            bc_q         <= bc_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            box_done_q   <= box_done_d;
        end
    end

    assign bus.in_ready   = !full;
    assign bus.busy       = (state_q == DRAW) || !empty;
    assign bus.vga_x      = vga_x_q;
    assign bus.vga_y      = vga_y_q;
    assign bus.vga_colour = vga_colour_q;
    assign bus.vga_plot   = vga_plot_q;
    assign bus.box_done   = box_done_q;
endmodule

// File: tb/tb_box_plotter.sv
// tb/tb_box_plotter.sv - self-checking bench for box_plotter against a transaction-level model
module tb_box_plotter;
    localparam int W     = 3;
    localparam int H     = 3;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    box_plotter_if bus();

    box_plotter #(.BOX_W(W), .BOX_H(H), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: a queue of pending boxes and the pixel index within the box on screen.
    logic [17:0] mq[$];
    logic [17:0] job = '0;
    bit          m_draw = 0;
    int          m_k = 0;
    int          e_x = 0, e_y = 0, e_c = 0, e_plot = 0, e_done = 0;
    int          cyc = 0, accepts = 0, accept_cyc = 0;
    int          px, py;
    bit          m_push;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mq.delete();
            m_draw = 0; m_k = 0;
            e_x = 0; e_y = 0; e_c = 0; e_plot = 0; e_done = 0;
        end else begin
            m_push = bus.in_valid && (mq.size() != DEPTH);
            e_plot = 0; e_done = 0;
            if (m_draw) begin
                px = int'(job[17:10]) + m_k % W;
                py = int'(job[9:3]) + m_k / W;
                e_x = px % 256;
                e_y = py % 128;
                e_c = int'(job[2:0]);
`ifdef BOX_PLOTTER_CLIP_EN
                e_plot = (px < 160 && py < 120) ? 1 : 0;
`else
                e_plot = 1;
`endif
                e_done = (m_k == W * H - 1) ? 1 : 0;
                m_k++;
                if (e_done != 0) m_draw = 0;
            end
            if (!m_draw && mq.size() > 0) begin
                job = mq.pop_front();
                m_draw = 1;
                m_k = 0;
            end
            if (m_push) begin
                mq.push_back({bus.in_x, bus.in_y, bus.in_colour});
                accepts++;
                accept_cyc = cyc;
            end
        end
    end

    bit cmp_en = 0;
    int plots = 0, dones = 0, first_cyc = 0, last_cyc = 0, done_cyc = 0;
    int done_x = 0, done_y = 0, busy_after = -1;
    int saw_x160 = 0, saw_y120 = 0;
    bit prev_done = 0;
    int lx[$], ly[$], dy[$], dc[$];

    always @(posedge clk) begin
        #1;
        if (cmp_en) begin
            check("in_ready",   int'(bus.in_ready),   (mq.size() != DEPTH) ? 1 : 0);
            check("busy",       int'(bus.busy),       (m_draw || mq.size() != 0) ? 1 : 0);
            check("vga_plot",   int'(bus.vga_plot),   e_plot);
            check("box_done",   int'(bus.box_done),   e_done);
            check("vga_x",      int'(bus.vga_x),      e_x);
            check("vga_y",      int'(bus.vga_y),      e_y);
            check("vga_colour", int'(bus.vga_colour), e_c);
        end
        if (prev_done) busy_after = int'(bus.busy);
        prev_done = bus.box_done;
        if (bus.vga_plot) begin
            plots++;
            if (plots == 1) first_cyc = cyc;
            last_cyc = cyc;
            lx.push_back(int'(bus.vga_x));
            ly.push_back(int'(bus.vga_y));
            if (bus.vga_x == 8'd160) saw_x160 = 1;
            if (bus.vga_y == 7'd120) saw_y120 = 1;
        end
        if (bus.box_done) begin
            dones++;
            done_cyc = cyc;
            done_x = int'(bus.vga_x);
            done_y = int'(bus.vga_y);
            dy.push_back(int'(bus.vga_y));
            dc.push_back(int'(bus.vga_colour));
        end
    end

    task automatic clear_log();
        plots = 0; dones = 0; first_cyc = 0; last_cyc = 0; done_cyc = 0;
        busy_after = -1; saw_x160 = 0; saw_y120 = 0; accepts = 0;
        lx.delete(); ly.delete(); dy.delete(); dc.delete();
    endtask

    task automatic drive(input bit v, input int x, input int y, input int c);
        bus.in_valid  = v;
        bus.in_x      = 8'(x);
        bus.in_y      = 7'(y);
        bus.in_colour = 3'(c);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((m_draw || mq.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) check({name, "_timeout"}, 1, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_k(input string name, input int k);
        int n = 0;
        while (!(m_draw && m_k == k) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check({name, "_timeout"}, 1, 0);
    endtask

    int ex[9] = '{38, 39, 40, 38, 39, 40, 38, 39, 40};
    int ey[9] = '{4, 4, 4, 5, 5, 5, 6, 6, 6};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(0, 0, 0, 0);
        repeat (2) @(negedge clk);
        check("rst_vga_plot", int'(bus.vga_plot), 0);
        check("rst_in_ready", int'(bus.in_ready), 1);
        check("rst_busy",     int'(bus.busy), 0);
        check("rst_vga_x",    int'(bus.vga_x), 0);
        check("rst_box_done", int'(bus.box_done), 0);
        reset = 1'b0;
        cmp_en = 1;
        @(negedge clk);

        // Single box at (38,4), white
        clear_log();
        drive(1, 38, 4, 7);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_idle("single");
        check("single_plots", plots, 9);
        check("single_latency", first_cyc - accept_cyc, 2);
        for (int i = 0; i < 9; i++) begin
            check("single_px_x", (i < lx.size()) ? lx[i] : -1, ex[i]);
            check("single_px_y", (i < ly.size()) ? ly[i] : -1, ey[i]);
        end
        check("single_dones", dones, 1);
        check("single_done_x", done_x, 40);
        check("single_done_y", done_y, 6);
        check("single_busy_after", busy_after, 0);

        // Burst of 8 requests under backpressure
        clear_log();
        for (int i = 0; i < 8; i++) begin
            drive(1, 20, 10 * i, i);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        wait_idle("burst");
        check("burst_accepts", accepts, 5);
        check("burst_plots", plots, 45);
        check("burst_contiguous", last_cyc - first_cyc + 1, 45);
        check("burst_dones", dones, 5);
        for (int i = 0; i < 5; i++)
            check("burst_order_y", (i < dy.size()) ? dy[i] : -1, 10 * i + 2);

        // Push on the same edge as a last-pixel pop with two entries queued
        clear_log();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 8 * i, 0, i);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        wait_k("pushpop", W * H - 1);
        check("pushpop_queued", int'(mq.size()), 2);
        check("pushpop_ready", int'(bus.in_ready), 1);
        drive(1, 40, 0, 4);
        @(negedge clk);
        drive(0, 0, 0, 0);
        check("pushpop_queued_after", int'(mq.size()), 2);
        wait_idle("pushpop");
        check("pushpop_dones", dones, 4);
        check("pushpop_plots", plots, 36);
        check("pushpop_contiguous", last_cyc - first_cyc + 1, 36);
        for (int i = 0; i < 4; i++)
            check("pushpop_colour", (i < dc.size()) ? dc[i] : -1, i + 1);

        // Reset in the middle of a box with two entries queued
        clear_log();
        for (int i = 1; i <= 3; i++) begin
            drive(1, 50, 10 * i, i);
            @(negedge clk);
        end
        drive(0, 0, 0, 0);
        wait_k("midreset", 5);
        check("midreset_plotting", int'(bus.vga_plot), 1);
        reset = 1'b1;
        #1;
        check("midreset_vga_plot", int'(bus.vga_plot), 0);
        check("midreset_in_ready", int'(bus.in_ready), 1);
        check("midreset_busy",     int'(bus.busy), 0);
        check("midreset_box_done", int'(bus.box_done), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        repeat (20) @(negedge clk);
        check("midreset_plots_after", plots, 0);
        check("midreset_dones_after", dones, 0);

        // Box straddling the visible-screen edge
        clear_log();
        drive(1, 158, 118, 2);
        @(negedge clk);
        drive(0, 0, 0, 0);
        wait_idle("edge");
        check("edge_dones", dones, 1);
        check("edge_done_cycle", done_cyc - accept_cyc, 10);
`ifdef BOX_PLOTTER_CLIP_EN
        check("edge_plots", plots, 4);
        check("edge_x160", saw_x160, 0);
        check("edge_y120", saw_y120, 0);
`else
        check("edge_plots", plots, 9);
        check("edge_x160", saw_x160, 1);
        check("edge_y120", saw_y120, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
